logic_gate_n_sweep: RTL and testbench
=====================================

// Module: logic_gate_n_sweep
// PURPOSE
//   Parametrised N-input reduction gate with run-time selectable function and registered output.
//   Built-in exhaustive sweep engine walks all 2^N input vectors, holds each for DWELL clocks and
//   counts truth-table ones, giving an on-board self-check of the gate.
//   Sits between board buttons/switches and LEDs in the basic_logic_design demos.
// PARAMETERS
//   N      3   number of gate inputs (1..8)
//   DWELL  12  clocks each sweep vector is held (>=1)
// PORTS
//   clk       in   1    system clock (12 MHz on board)
//   rstn      in   1    asynchronous active-low reset
//   x         in   N    live gate inputs (used in IDLE)
//   op        in   3    function select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 const 0
//   start     in   1    sweep request, level sampled in IDLE
//   z0        out  1    registered gate output
//   busy      out  1    high while sweeping
//   done      out  1    one-clock pulse at sweep end
//   vec       out  N    vector currently applied (0 in IDLE)
//   ones_cnt  out  N+1  number of vectors giving 1 in last sweep
// BEHAVIOUR
//   Reset: one clock; reset is asynchronous and active-low (rstn). While rstn=0:
//     z0=0, busy=0, done=0, vec=0, ones_cnt=0, dcnt=0, state=IDLE.
//   FSM states: IDLE -> SWEEP -> DONE -> IDLE.
//   IDLE:
//     - z0 <= f(x, op) each clock; latency 1 clk.
//     - start=1 -> SWEEP; op latched into op_q; vec=0; dcnt=0; ones_cnt cleared to 0.
//   SWEEP:
//     - busy=1; z0 <= f(vec, op_q); live x and op are ignored.
//     - dcnt counts 0..DWELL-1. In cycle dcnt==DWELL-1, ones_cnt += f(vec, op_q) (combinational).
//     - After that cycle: dcnt=0, vec=vec+1.
//     - When vec == 2^N-1 and dcnt==DWELL-1, go to DONE; vec does not wrap.
//     - busy is high for exactly 2^N*DWELL clocks.
//   DONE:
//     - one clock; done=1; busy=0; vec=0; next state IDLE.
//   Other rules:
//     - ones_cnt is stable from done until the next accepted start; max value 2^N fits in N+1 bits.
//     - start in SWEEP/DONE is ignored (no restart, no queueing).
//     - start held high continuously re-triggers a new sweep on the first IDLE clock after DONE.
//     - op=6/7: z0=0 and the sweep gives ones_cnt=0.
//     - rstn low mid-sweep aborts immediately to the reset values; no done pulse.
//     - N=1: AND/OR reduce to buffer, NAND/NOR/XNOR to inverter, XOR to buffer.
// CONFIGURATION
//   LOGIC_GATE_SYNC_EN defined:
//     - x passes through a 2-FF synchroniser (reset to 0) before the gate.
//     - IDLE latency x->z0 becomes 3 clocks.
//     - Sweep is unaffected, because vec bypasses the synchroniser.
//   Not defined: x feeds the gate directly; latency 1 clock.
// TESTING (N=3, DWELL=4)
//   - Reset: rstn=0 with start=1, x=7 -> z0, busy, done, vec, ones_cnt all 0.
//     Release rstn -> one sweep begins.
//   - IDLE, op=0: x=3'b111 -> z0=1 one clock later; x=3'b110 -> z0=0.
//     With SYNC_EN, each response arrives after 3 clocks.
//   - op=0, start pulse:
//     - busy=1 for 32 clks; vec steps 0..7 every 4 clks.
//     - z0=1 only while vec=7.
//     - done pulse, then ones_cnt=1.
//   - Sweep counts:
//     - Expected ones_cnt: OR=7, XOR=4, NAND=7, NOR=1, XNOR=4, op=6 -> 0.
//     - DWELL=1 with op=1 -> busy=8 clks and ones_cnt=7.
//   - Mid-sweep stimulus at vec=3:
//     - start pulse and op change to 1 -> ignored; ones_cnt still 1 (AND) and busy still 32 clks.
//   - rstn=0 at vec=5 -> all outputs 0 immediately; no done; IDLE resumes after release.

Source files
------------

// File: rtl/logic_gate_n_sweep_if.sv
// Gate/sweep bus for logic_gate_n_sweep: live inputs and requests in, gate and sweep status out.
interface logic_gate_n_sweep_if #(
    parameter int N = 3
);
    logic [N-1:0] x;
    logic [2:0]   op;
    logic         start;
    logic         z0;
    logic         busy;
    logic         done;
    logic [N-1:0] vec;
    logic [N:0]   ones_cnt;

    modport master (
        output x, op, start,
        input  z0, busy, done, vec, ones_cnt
    );

    modport slave (
        input  x, op, start,
        output z0, busy, done, vec, ones_cnt
    );
endinterface

// File: rtl/logic_gate_n_sweep.sv
// N-input reduction gate with registered output and an exhaustive truth-table sweep engine.
// Optional LOGIC_GATE_SYNC_EN adds a 2-FF synchroniser on the live x inputs.
module logic_gate_n_sweep #(
    parameter int N     = 3,
    parameter int DWELL = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    logic_gate_n_sweep_if.slave  bus
);
    localparam int           DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
    localparam logic [N-1:0]  VLAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    op_q;
    logic [N-1:0]  vec_q;
    logic [DW-1:0] dcnt;
    logic [N:0]    ones_q;
    logic          z0_q;
    logic [N-1:0]  x_g;
    logic          live_bit;
    logic          sweep_bit;
    logic          dwell_end;

    function automatic logic gate_f(input logic [N-1:0] v, input logic [2:0] f);
        case (f)
            3'd0:    return &v;
            3'd1:    return |v;
            3'd2:    return ^v;
            3'd3:    return ~&v;
            3'd4:    return ~|v;
            3'd5:    return ~^v;
            default: return 1'b0;
        endcase
    endfunction

`ifdef LOGIC_GATE_SYNC_EN
    logic [N-1:0] x_s1, x_s2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_s1 <= '0;
            x_s2 <= '0;
        end else begin
            x_s1 <= bus.x;
            x_s2 <= x_s1;
        end
    end

    assign x_g = x_s2;
`else
    assign x_g = bus.x;
`endif

    assign live_bit  = gate_f(x_g, bus.op);
    assign sweep_bit = gate_f(vec_q, op_q);
    assign dwell_end = (dcnt == DLAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SWEEP;
            SWEEP:   if (dwell_end && vec_q == VLAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // In DONE the gate already follows the live inputs again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            op_q   <= '0;
            vec_q  <= '0;
            dcnt   <= '0;
            ones_q <= '0;
            z0_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    z0_q <= live_bit;
                    if (bus.start) begin
                        op_q   <= bus.op;
                        vec_q  <= '0;
                        dcnt   <= '0;
                        ones_q <= '0;
                    end
                end
                SWEEP: begin
                    z0_q <= sweep_bit;
                    if (dwell_end) begin
                        ones_q <= ones_q + {{N{1'b0}}, sweep_bit};
                        dcnt   <= '0;
                        // Last vector returns vec to 0 for DONE instead of wrapping into another pass.
                        vec_q  <= (vec_q == VLAST) ? '0 : vec_q + N'(1);
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: begin
                    z0_q <= live_bit;
                end
                default: ;
            endcase
        end
    end

    assign bus.z0       = z0_q;
    assign bus.busy     = (state == SWEEP);
    assign bus.done     = (state == DONE);
    assign bus.vec      = vec_q;
    assign bus.ones_cnt = ones_q;
endmodule

// File: tb/tb_logic_gate_n_sweep.sv
// Self-checking bench for logic_gate_n_sweep: cycle model plus directed sweep and latency vectors.
module tb_logic_gate_n_sweep;
    localparam int N  = 3;
    localparam int D  = 4;
    localparam int NV = 8;
`ifdef LOGIC_GATE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic_gate_n_sweep_if #(.N(N)) bus ();
    logic_gate_n_sweep_if #(.N(N)) bus1 ();

    logic_gate_n_sweep #(.N(N), .DWELL(D)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic_gate_n_sweep #(.N(N), .DWELL(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Gate truth from the number of set inputs.
    function automatic int g(input int v, input logic [2:0] op);
        int p;
        p = $countones(v);
        case (op)
            3'd0:    return (p == N) ? 1 : 0;
            3'd1:    return (p > 0) ? 1 : 0;
            3'd2:    return p % 2;
            3'd3:    return (p != N) ? 1 : 0;
            3'd4:    return (p == 0) ? 1 : 0;
            3'd5:    return (p % 2 == 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int cnt(input int lim, input logic [2:0] op);
        int c;
        c = 0;
        for (int v = 0; v < lim; v++) c += g(v, op);
        return c;
    endfunction

    // Model: mode 0 idle, 1 sweeping (m_k clocks elapsed), 2 done.
    int         m_mode = 0;
    int         m_k = 0;
    int         m_final = 0;
    logic [2:0] m_opq = '0;
    int         m_z0 = 0;
    int         h1 = 0;
    int         h2 = 0;

    always @(posedge clk) begin : model
        int xd;
        if (!rstn) begin
            m_mode = 0; m_k = 0; m_final = 0; m_opq = '0; m_z0 = 0; h1 = 0; h2 = 0;
        end else begin
            xd = (LAT == 3) ? h2 : int'(bus.x);
            case (m_mode)
                0: begin
                    m_z0 = g(xd, bus.op);
                    if (bus.start) begin
                        m_mode = 1; m_k = 0; m_opq = bus.op;
                    end
                end
                1: begin
                    m_z0 = g(m_k / D, m_opq);
                    m_k++;
                    if (m_k == NV * D) begin
                        m_mode = 2;
                        m_final = cnt(NV, m_opq);
                    end
                end
                default: begin
                    m_z0 = g(xd, bus.op);
                    m_mode = 0;
                end
            endcase
            h2 = h1;
            h1 = int'(bus.x);
        end
        #1;
        chk("model z0", bus.z0, m_z0);
        chk("model busy", bus.busy, (m_mode == 1) ? 1 : 0);
        chk("model done", bus.done, (m_mode == 2) ? 1 : 0);
        chk("model vec", bus.vec, (m_mode == 1) ? m_k / D : 0);
        chk("model ones_cnt", bus.ones_cnt, (m_mode == 1) ? cnt(m_k / D, m_opq) : m_final);
    end

    task automatic wait_done(input string nm, input int exp_busy, input int exp_ones,
                             input bit poke, input bit hold);
        int busy_n;
        bit seen;
        bit poked;
        busy_n = 0; seen = 0; poked = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (poke && !poked && bus.vec == 3'd3) begin
                bus.start = 1'b1;
                bus.op    = 3'd1;
                poked     = 1;
            end
            if (bus.done) seen = 1;
        end
        chk({nm, " done seen"}, seen, 1);
        chk({nm, " busy clks"}, busy_n, exp_busy);
        chk({nm, " ones_cnt"}, bus.ones_cnt, exp_ones);
    endtask

    task automatic run_sweep(input string nm, input logic [2:0] op, input int exp_ones, input bit poke);
        @(negedge clk);
        bus.op    = op;
        bus.start = 1'b1;
        wait_done(nm, 32, exp_ones, poke, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int       found;
        int       dcount;
        int       b1;
        bit       s1;
        logic [2:0] ops [6];
        int       exp [6];
        ops = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        exp = '{7, 4, 7, 1, 4, 0};

        bus.x = 3'd7; bus.op = 3'd0; bus.start = 1'b1;
        bus1.x = '0; bus1.op = 3'd1; bus1.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset z0", bus.z0, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset vec", bus.vec, 0);
        chk("reset ones_cnt", bus.ones_cnt, 0);

        // Start held through reset: the first clock after release launches an AND sweep.
        rstn = 1'b1;
        wait_done("post-reset AND", 32, 1, 0, 0);

        @(negedge clk);
        bus.op = 3'd0; bus.x = 3'b111;
        repeat (LAT) @(posedge clk);
        #1 chk("idle and 111", bus.z0, 1);
        @(negedge clk);
        bus.x = 3'b110;
        repeat (LAT) @(posedge clk);
        #1 chk("idle and 110", bus.z0, 0);

        bus.x = 3'd0;
        run_sweep("AND", 3'd0, 1, 0);
        for (int i = 0; i < 6; i++) run_sweep($sformatf("op%0d", ops[i]), ops[i], exp[i], 0);
        run_sweep("AND poked", 3'd0, 1, 1);

        // Start held: DONE -> one IDLE clock -> new sweep.
        @(negedge clk);
        bus.op = 3'd2; bus.start = 1'b1;
        wait_done("XOR held", 32, 4, 0, 1);
        @(negedge clk);
        chk("retrigger idle gap", bus.busy, 0);
        @(negedge clk);
        chk("retrigger busy", bus.busy, 1);
        wait_done("XOR second", 31, 4, 0, 0);

        // Abort an OR sweep at vec=5.
        @(negedge clk);
        bus.op = 3'd1; bus.start = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.vec == 3'd5) found = 1;
        end
        chk("reach vec5", found, 1);
        chk("ones at vec5", bus.ones_cnt, 4);
        rstn = 1'b0;
        #1;
        chk("abort z0", bus.z0, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        chk("abort vec", bus.vec, 0);
        chk("abort ones_cnt", bus.ones_cnt, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcount++;
        end
        chk("no activity after abort", dcount, 0);

        // DWELL=1 instance: OR sweep.
        @(negedge clk);
        bus1.op = 3'd1; bus1.start = 1'b1;
        b1 = 0; s1 = 0;
        for (int i = 0; i < 50 && !s1; i++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            if (bus1.busy) b1++;
            if (bus1.done) s1 = 1;
        end
        chk("dwell1 done seen", s1, 1);
        chk("dwell1 busy clks", b1, 8);
        chk("dwell1 ones_cnt", bus1.ones_cnt, 7);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
